// File: rtl/fx_sqrt_seq_if.sv
// fx_sqrt_seq_if: start/valid handshake and data bus for the sequential square root.
// The requester (pixel_gen) uses the master modport; fx_sqrt_seq uses the slave modport.
interface fx_sqrt_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] rad;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;

  modport master (
    output start,
    output rad,
    input  busy,
    input  valid,
    input  root,
    input  rem
  );

  modport slave (
    input  start,
    input  rad,
    output busy,
    output valid,
    output root,
    output rem
  );
endinterface

// File: rtl/fx_sqrt_seq.sv
// fx_sqrt_seq: sequential Q(WIDTH-FBITS).FBITS square root, restoring digit-by-digit,
// one root bit per clock. Returns root (zero-extended) and integer remainder
// (rad<<FBITS) - root_raw^2.
// Optional feature macro: FX_SQRT_ROUND_EN adds a ROUND state that rounds the root
// to nearest (rem still reports the truncated remainder), costing one extra cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, busy=0
// CALC  | ITER iterations, then one cycle to register the result
// ROUND | (FX_SQRT_ROUND_EN only) round root to nearest, register result
// DONE  | valid=1 for one cycle, busy=0; start here begins the next op
module fx_sqrt_seq #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic          clk,
  input  logic          rst,
  fx_sqrt_seq_if.slave  bus
);

  localparam int XW   = WIDTH + FBITS;
  localparam int ITER = XW / 2;
  localparam int RW   = WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [RW-1:0]     rem_p_q, rem_p_d;
  logic [ITER-1:0]   q_q, q_d;
  logic [WIDTH-1:0]  root_q, root_d;
  logic [WIDTH-1:0]  rem_q, rem_d;

  logic [RW-1:0]     rem_s;
  logic [RW-1:0]     trial;
  logic              take;
  logic              busy;
  logic              valid;

  // One restoring step: bring in the next radicand digit pair, try subtracting {q,01}.
  always_comb begin
    rem_s = {rem_p_q[RW-3:0], x_q[XW-1 -: 2]};
    trial = RW'({q_q, 2'b01});
    take  = (rem_s >= trial);
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rem_p_d = rem_p_q;
    q_d     = q_q;
    root_d  = root_q;
    rem_d   = rem_q;
    busy    = 1'b0;
    valid   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CALC;
          cnt_d   = CW'(ITER);
          x_d     = {bus.rad, {FBITS{1'b0}}};
          rem_p_d = '0;
          q_d     = '0;
        end
      end

      S_CALC: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          x_d     = {x_q[XW-3:0], 2'b00};
          rem_p_d = take ? (rem_s - trial) : rem_s;
          q_d     = {q_q[ITER-2:0], take};
        end else begin
`ifdef FX_SQRT_ROUND_EN
          // Raw root/remainder stay in q/rem_p; ROUND registers the outputs so
          // root does not change twice while busy.
          state_d = S_ROUND;
`else
          state_d = S_DONE;
          root_d  = WIDTH'(q_q);
          rem_d   = WIDTH'(rem_p_q);
`endif
        end
      end

      S_ROUND: begin
        busy    = 1'b1;
        state_d = S_DONE;
`ifdef FX_SQRT_ROUND_EN
        root_d  = WIDTH'(q_q) + WIDTH'(rem_p_q > RW'(q_q));
        rem_d   = WIDTH'(rem_p_q);
`endif
      end

      S_DONE: begin
        valid = 1'b1;
        if (bus.start) begin
          state_d = S_CALC;
          cnt_d   = CW'(ITER);
          x_d     = {bus.rad, {FBITS{1'b0}}};
          rem_p_d = '0;
          q_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      rem_p_q <= '0;
      q_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rem_p_q <= rem_p_d;
      q_q     <= q_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy  = busy;
  assign bus.valid = valid;
  assign bus.root  = root_q;
  assign bus.rem   = rem_q;

endmodule

// File: tb/tb_fx_sqrt_seq.sv
// tb_fx_sqrt_seq: directed and randomized checks of fx_sqrt_seq against an
// arithmetic square-root reference. Honours FX_SQRT_ROUND_EN when defined.
module tb_fx_sqrt_seq;

  localparam int WIDTH = 32;
  localparam int FBITS = 16;
  localparam int ITER  = (WIDTH + FBITS) / 2;
`ifdef FX_SQRT_ROUND_EN
  localparam int LAT   = ITER + 2;
  localparam bit RND   = 1'b1;
`else
  localparam int LAT   = ITER + 1;
  localparam bit RND   = 1'b0;
`endif
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fx_sqrt_seq_if #(.WIDTH(WIDTH)) bus ();

  fx_sqrt_seq #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: greedy bit-by-bit floor sqrt of rad*2^FBITS using 64-bit squares.
  task automatic ref_sqrt(input logic [31:0] r, output logic [31:0] root,
                          output logic [31:0] rem);
    longint unsigned x, s, t;
    x = longint'(r) << FBITS;
    s = 0;
    for (int b = ITER - 1; b >= 0; b--) begin
      t = s | (64'd1 << b);
      if (t * t <= x) s = t;
    end
    rem  = 32'(x - s * s);
    root = 32'(s);
    if (RND && (longint'(rem) > s)) root = 32'(s + 1);
  endtask

  // One request: start for a single cycle, optional ignored start+rad change at
  // cycle ign_k, then check latency, busy profile, stability and result.
  task automatic run_op(input string tag, input logic [31:0] r, input logic [31:0] er,
                        input logic [31:0] erm, input int ign_k, input logic [31:0] alt);
    int k, busy_n, unstable;
    logic [31:0] root0, rem0;
    @(negedge clk);
    bus.rad   = r;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; busy_n = 0; unstable = 0;
    root0 = bus.root; rem0 = bus.rem;
    while (!bus.valid && k < TMO) begin
      if (bus.busy) busy_n++;
      if (bus.root !== root0 || bus.rem !== rem0) unstable++;
      if (k == ign_k) begin
        bus.rad   = alt;
        bus.start = 1'b1;
      end else if (k == ign_k + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 64'(k), 64'(LAT));
    chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(LAT));
    chk({tag, ".stable"}, 64'(unstable), 64'd0);
    chk({tag, ".busy_at_valid"}, 64'(bus.busy), 64'd0);
    chk({tag, ".root"}, 64'(bus.root), 64'(er));
    chk({tag, ".rem"}, 64'(bus.rem), 64'(erm));
    @(negedge clk);
    chk({tag, ".valid_pulse"}, 64'(bus.valid), 64'd0);
  endtask

  task automatic run_model(input string tag, input logic [31:0] r, input int ign_k,
                           input logic [31:0] alt);
    logic [31:0] er, erm;
    ref_sqrt(r, er, erm);
    run_op(tag, r, er, erm, ign_k, alt);
  endtask

  initial begin
    logic [31:0] r1, r2, e1, m1, e2, m2, ra;
    int k, vcnt;

    bus.start = 1'b0;
    bus.rad   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.busy",  64'(bus.busy),  64'd0);
    chk("reset.valid", 64'(bus.valid), 64'd0);
    chk("reset.root",  64'(bus.root),  64'd0);
    chk("reset.rem",   64'(bus.rem),   64'd0);
    rst = 1'b0;

    // Directed vectors with hand-derived results.
    run_op("t1_four", 32'h0004_0000, 32'h0002_0000, 32'h0, -1, 32'h0);
    run_op("t2_two",  32'h0002_0000, RND ? 32'h0001_6A0A : 32'h0001_6A09, 32'h0002_8BAF, -1, 32'h0);
    run_op("t3_lsb",  32'h0000_0001, 32'h0000_0100, 32'h0, -1, 32'h0);
    run_op("t3_zero", 32'h0000_0000, 32'h0, 32'h0, -1, 32'h0);
    run_op("t5_ignore", 32'h0019_0000, 32'h0005_0000, 32'h0, 10, 32'hDEAD_BEEF);
    run_op("t4_ones", 32'hFFFF_FFFF, RND ? 32'h0100_0000 : 32'h00FF_FFFF, 32'h01FE_FFFF, -1, 32'h0);

    // Reset in the middle of CALC aborts the op and clears the outputs.
    @(negedge clk);
    bus.rad   = 32'h1234_5678;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst.busy",  64'(bus.busy),  64'd0);
    chk("t6_rst.valid", 64'(bus.valid), 64'd0);
    chk("t6_rst.root",  64'(bus.root),  64'd0);
    chk("t6_rst.rem",   64'(bus.rem),   64'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) vcnt++;
    end
    chk("t6_rst.stray_valid", 64'(vcnt), 64'd0);
    run_model("t6_fresh", 32'h1234_5678, -1, 32'h0);

    // Back-to-back: start held through op1, accepted in DONE with rad=r2.
    r1 = 32'h0009_0000;
    r2 = $urandom;
    ref_sqrt(r1, e1, m1);
    ref_sqrt(r2, e2, m2);
    @(negedge clk);
    bus.rad   = r1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.rad   = r2;
    k = 0;
    while (!bus.valid && k < TMO) begin
      @(negedge clk);
      k++;
    end
    chk("t5_b2b.lat1",  64'(k), 64'(LAT));
    chk("t5_b2b.root1", 64'(bus.root), 64'(e1));
    chk("t5_b2b.rem1",  64'(bus.rem),  64'(m1));
    chk("t5_b2b.busy1", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.valid && k < TMO) begin
      @(negedge clk);
      k++;
    end
    // Valid pulses are separated by ITER+1 non-valid cycles (LAT+1 cycles apart
    // edge to edge, since DONE itself is the accepting cycle).
    chk("t5_b2b.gap",   64'(k + 1), 64'(LAT + 1));
    chk("t5_b2b.root2", 64'(bus.root), 64'(e2));
    chk("t5_b2b.rem2",  64'(bus.rem),  64'(m2));
    @(negedge clk);

    // Randomized radicands across magnitudes, some with an ignored start mid-op.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if (i % 4 == 3)
        run_model($sformatf("rand%0d", i), ra, $urandom_range(1, ITER - 3), $urandom);
      else
        run_model($sformatf("rand%0d", i), ra, -1, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
